// File: rtl/codec_reg_arbiter.sv
// -----------------------------------------------------------------------------
// codec_reg_arbiter
//
// Shares one codec I2C register-write engine between N_REQ requesters.
// Requesters are granted round-robin; the granted 16-bit register word is
// framed into a 24-bit I2C write {I2C_ADDR, 1'b0 (write), reg_addr, reg_data},
// launched on the byte engine, and supervised for completion, ACK status and
// timeout. The outcome is returned as a one-cycle done or error pulse on the
// requester's own bit.
//
// Optional feature macro: CODEC_ARB_RETRY_EN
//   defined   : a NACKed frame is re-sent up to 2 more times before o_err.
//   undefined : the first NACK ends the transaction with o_err.
//
// Handshakes:
//   Requester side: i_req[k] is a level request; i_req_word slice k must be
//   valid whenever i_req[k] is high. o_gnt[k] pulses for one cycle when the
//   word has been taken; the requester drops i_req[k] in the following cycle.
//   Ungranted requests stay pending. o_done[k] / o_err[k] pulse once per grant.
//   Engine side: o_wr_start pulses once per attempt with o_wr_frame stable;
//   the engine answers with a one-cycle i_wr_done, i_wr_ack_ok qualified by
//   it. o_wr_abort pulses when the attempt timed out.
//
// Ports:
//   i_clk, i_rst       clock, synchronous active-high reset
//   i_req, i_req_word  per-requester request bits and 16-bit words
//   o_gnt, o_done,     per-requester one-cycle grant / success / failure
//   o_err
//   o_busy             high whenever the FSM is not in IDLE
//   o_wr_start,        engine launch pulse, frame, timeout abort pulse
//   o_wr_frame,
//   o_wr_abort
//   i_wr_done,         engine completion pulse and ACK status
//   i_wr_ack_ok
//   o_dbg_state        current FSM state encoding (0 IDLE, 1 GRANT,
//                      2 START, 3 WAIT, 4 DONE)
// -----------------------------------------------------------------------------
module codec_reg_arbiter #(
    parameter int         N_REQ    = 2,
    parameter logic [6:0] I2C_ADDR = 7'b0011010,
    parameter int         TIMEOUT  = 1023
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [N_REQ-1:0]     i_req,
    input  logic [16*N_REQ-1:0]  i_req_word,
    output logic [N_REQ-1:0]     o_gnt,
    output logic [N_REQ-1:0]     o_done,
    output logic [N_REQ-1:0]     o_err,
    output logic                 o_busy,
    output logic                 o_wr_start,
    output logic [23:0]          o_wr_frame,
    output logic                 o_wr_abort,
    input  logic                 i_wr_done,
    input  logic                 i_wr_ack_ok,
    output logic [2:0]           o_dbg_state
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    localparam logic [IDX_W:0]   N_REQ_W   = (IDX_W + 1)'(N_REQ);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_REQ - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [N_REQ-1:0] ONE_HOT_0 = N_REQ'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_GRANT = 3'd1,
        S_START = 3'd2,
        S_WAIT  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t state, state_nxt;

    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] idx;
    logic [23:0]      frame_q;
    logic [CNT_W-1:0] cnt;
    logic             ok_flag;
    logic             err_flag;
    logic             to_flag;

    logic             timeout_hit;
    logic             retry_ok;

    // Round-robin search starting at ptr, wrapping modulo N_REQ.
    logic             sel_found;
    logic [IDX_W-1:0] sel_idx;
    logic [IDX_W:0]   rr_sum;
    logic [IDX_W-1:0] rr_cand;
    logic [IDX_W-1:0] ptr_nxt;

    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        rr_sum    = '0;
        rr_cand   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            rr_sum = {1'b0, ptr} + (IDX_W + 1)'(i);
            if (rr_sum >= N_REQ_W) begin
                rr_sum = rr_sum - N_REQ_W;
            end
            rr_cand = rr_sum[IDX_W-1:0];
            if (!sel_found && i_req[rr_cand]) begin
                sel_found = 1'b1;
                sel_idx   = rr_cand;
            end
        end
    end

    assign ptr_nxt     = (sel_idx == LAST_IDX) ? '0 : sel_idx + IDX_W'(1);
    assign timeout_hit = (cnt == TIMEOUT_C);

`ifdef CODEC_ARB_RETRY_EN
    // Number of retries already spent on the current grant (0..2).
    localparam logic [1:0] MAX_RETRY = 2'd2;
    logic [1:0] retry_cnt;

    assign retry_ok = (retry_cnt != MAX_RETRY);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            retry_cnt <= '0;
        end else if (state == S_GRANT) begin
            retry_cnt <= '0;
        end else if (state == S_WAIT && i_wr_done && !i_wr_ack_ok && retry_ok) begin
            retry_cnt <= retry_cnt + 2'd1;
        end
    end
`else
    assign retry_ok = 1'b0;
`endif

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic. A completion in the timeout cycle wins over the abort.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (sel_found) state_nxt = S_GRANT;
            S_GRANT: state_nxt = S_START;
            S_START: state_nxt = S_WAIT;
            S_WAIT: begin
                if (i_wr_done) begin
                    if (!i_wr_ack_ok && retry_ok) begin
                        state_nxt = S_START;
                    end else begin
                        state_nxt = S_DONE;
                    end
                end else if (timeout_hit) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Datapath: grant capture, timeout counter, outcome flags.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ptr      <= '0;
            idx      <= '0;
            frame_q  <= '0;
            cnt      <= '0;
            ok_flag  <= 1'b0;
            err_flag <= 1'b0;
            to_flag  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (sel_found) begin
                        idx     <= sel_idx;
                        ptr     <= ptr_nxt;
                        frame_q <= {I2C_ADDR, 1'b0, i_req_word[16*sel_idx +: 16]};
                    end
                end
                S_GRANT: begin
                    ok_flag  <= 1'b0;
                    err_flag <= 1'b0;
                    to_flag  <= 1'b0;
                end
                S_START: begin
                    cnt <= '0;
                end
                S_WAIT: begin
                    if (i_wr_done) begin
                        if (i_wr_ack_ok) begin
                            ok_flag <= 1'b1;
                        end else if (!retry_ok) begin
                            err_flag <= 1'b1;
                        end
                    end else if (timeout_hit) begin
                        err_flag <= 1'b1;
                        to_flag  <= 1'b1;
                    end else begin
                        // Leaving WAIT on timeout_hit keeps the counter
                        // saturated at TIMEOUT rather than wrapping.
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs decoded from state and captured flags.
    always_comb begin
        o_gnt      = '0;
        o_done     = '0;
        o_err      = '0;
        o_wr_start = 1'b0;
        o_wr_abort = 1'b0;
        o_busy     = (state != S_IDLE);
        case (state)
            S_GRANT: o_gnt = ONE_HOT_0 << idx;
            S_START: o_wr_start = 1'b1;
            S_DONE: begin
                if (ok_flag)  o_done = ONE_HOT_0 << idx;
                if (err_flag) o_err  = ONE_HOT_0 << idx;
                o_wr_abort = to_flag;
            end
            default: ;
        endcase
    end

    assign o_wr_frame  = frame_q;
    assign o_dbg_state = state;

endmodule

// File: tb/tb_codec_reg_arbiter.sv
module tb_codec_reg_arbiter;

  localparam int N_REQ   = 2;
  localparam int TIMEOUT = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [N_REQ-1:0]  req;
  logic [16*N_REQ-1:0] req_word;
  logic [N_REQ-1:0]  gnt, done, err;
  logic              busy, wr_start, wr_abort;
  logic [23:0]       wr_frame;
  logic              wr_done, wr_ack_ok;
  logic [2:0]        dbg_state;

  int checks = 0;
  int errors = 0;

  logic [N_REQ-1:0] exp_q[$];

  // ---------------------------------------------------------------------------
  // clock / reset
  // ---------------------------------------------------------------------------
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "time limit");
  end

  codec_reg_arbiter #(
    .N_REQ(N_REQ),
    .I2C_ADDR(7'b0011010),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_req(req),
    .i_req_word(req_word),
    .o_gnt(gnt),
    .o_done(done),
    .o_err(err),
    .o_busy(busy),
    .o_wr_start(wr_start),
    .o_wr_frame(wr_frame),
    .o_wr_abort(wr_abort),
    .i_wr_done(wr_done),
    .i_wr_ack_ok(wr_ack_ok),
    .o_dbg_state(dbg_state)
  );

  // ---------------------------------------------------------------------------
  // scoreboard helpers
  // ---------------------------------------------------------------------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // All driver tasks start and end at posedge + 1.
  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    wr_done = 1'b0;
    wr_ack_ok = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_gnt"},   gnt, 0);
    check({tag, "_done"},  done, 0);
    check({tag, "_err"},   err, 0);
    check({tag, "_busy"},  busy, 0);
    check({tag, "_start"}, wr_start, 0);
    check({tag, "_abort"}, wr_abort, 0);
    check({tag, "_state"}, dbg_state, 0);
  endtask

  // Runs one transaction: requesters in mask raise req and all drop it after
  // the grant. The engine model answers delay cycles after each start
  // (never when delay < 0), NACKing the first nacks attempts.
  task automatic run_write(input logic [N_REQ-1:0] mask, input int nacks, input int delay,
                           output logic [N_REQ-1:0] first_gnt, output logic [23:0] gnt_frame,
                           output int gnts, output int starts,
                           output logic [N_REQ-1:0] done_v, output logic [N_REQ-1:0] err_v,
                           output int abort_n, output int start_cyc, output int fin_cyc,
                           output int abort_cyc, output logic both, output logic finished);
    logic [N_REQ-1:0] req_v;
    int resp;
    first_gnt = '0; gnt_frame = '0; gnts = 0; starts = 0; done_v = '0; err_v = '0;
    abort_n = 0; start_cyc = -1; fin_cyc = -1; abort_cyc = -1; both = 1'b0;
    finished = 1'b0; resp = -1; req_v = mask;
    for (int cyc = 0; cyc < 100; cyc++) begin
      req = req_v;
      wr_done = (cyc == resp);
      wr_ack_ok = (starts > nacks);
      @(negedge clk);
      if (gnt != '0) begin
        if (gnts == 0) begin
          first_gnt = gnt;
          gnt_frame = wr_frame;
        end
        gnts++;
        req_v = '0;
      end
      if (wr_start) begin
        starts++;
        start_cyc = cyc;
        if (delay >= 0) resp = cyc + delay;
      end
      if ((done & err) != '0) both = 1'b1;
      if (done != '0 || err != '0) begin
        done_v |= done;
        err_v  |= err;
        fin_cyc = cyc;
      end
      if (wr_abort) begin
        abort_n++;
        abort_cyc = cyc;
      end
      if (fin_cyc >= 0 && cyc > fin_cyc && !busy) finished = 1'b1;
      @(posedge clk);
      #1;
      if (finished) break;
    end
    req = '0;
    wr_done = 1'b0;
    wr_ack_ok = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // single-request vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [1:0] req;
    logic       wr_done;
    logic       ack;
    logic [1:0] gnt;
    logic [1:0] done;
    logic [1:0] err;
    logic       busy;
    logic       start;
    logic       abort;
    logic       chk_frame;
    logic [2:0] st;
  } vec_t;

  vec_t vecs [0:12];

  logic [N_REQ-1:0] first_gnt, done_v, err_v;
  logic [23:0]      gnt_frame;
  int               gnts, starts, abort_n, start_cyc, fin_cyc, abort_cyc;
  logic             both, finished;

  initial begin
    // req, wr_done, ack, gnt, done, err, busy, start, abort, chk_frame, state
    vecs[0]  = '{2'b01, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0};
    vecs[1]  = '{2'b01, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 3'd1};
    vecs[2]  = '{2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1, 3'd2};
    for (int i = 3; i <= 9; i++)
      vecs[i] = '{2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 3'd3};
    vecs[10] = '{2'b00, 1'b1, 1'b1, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 3'd3};
    vecs[11] = '{2'b00, 1'b0, 1'b0, 2'b00, 2'b01, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 3'd4};
    vecs[12] = '{2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0};

    req_word = {16'h0000, 16'h0E42};
    do_reset();
    @(negedge clk);
    check_quiet("reset");
    check("reset_frame", wr_frame, 24'h000000);
    @(posedge clk);
    #1;

    for (int i = 0; i <= 12; i++) begin
      req = vecs[i].req;
      wr_done = vecs[i].wr_done;
      wr_ack_ok = vecs[i].ack;
      @(negedge clk);
      check($sformatf("v%0d_gnt", i),   gnt,      vecs[i].gnt);
      check($sformatf("v%0d_done", i),  done,     vecs[i].done);
      check($sformatf("v%0d_err", i),   err,      vecs[i].err);
      check($sformatf("v%0d_busy", i),  busy,     vecs[i].busy);
      check($sformatf("v%0d_start", i), wr_start, vecs[i].start);
      check($sformatf("v%0d_abort", i), wr_abort, vecs[i].abort);
      check($sformatf("v%0d_state", i), dbg_state, vecs[i].st);
      if (vecs[i].chk_frame)
        check($sformatf("v%0d_frame", i), wr_frame, 24'h340E42);
      @(posedge clk);
      #1;
    end
    req = '0;
    wr_done = 1'b0;
    wr_ack_ok = 1'b0;

    // -------------------------------------------------------------------------
    // round-robin fairness with both requesters active
    // -------------------------------------------------------------------------
    begin
      logic [N_REQ-1:0] req_v;
      int gcnt [N_REQ];
      int resp, dones;
      do_reset();
      req_word = {16'h1234, 16'h0E42};
      exp_q = {2'b01, 2'b10, 2'b01, 2'b10};
      req_v = 2'b11;
      resp = -1;
      dones = 0;
      for (int k = 0; k < N_REQ; k++) gcnt[k] = 0;
      for (int cyc = 0; cyc < 300 && dones < 4; cyc++) begin
        req = req_v;
        wr_done = (cyc == resp);
        wr_ack_ok = 1'b1;
        @(negedge clk);
        if (gnt != '0) begin
          if (exp_q.size() == 0) check("rr_extra_gnt", gnt, 0);
          else check("rr_gnt", gnt, exp_q.pop_front());
          for (int k = 0; k < N_REQ; k++) if (gnt[k]) gcnt[k]++;
          req_v &= ~gnt;
        end
        if (wr_start) resp = cyc + 3;
        if (done != '0) begin
          dones++;
          for (int k = 0; k < N_REQ; k++)
            if (done[k] && gcnt[k] < 2) req_v[k] = 1'b1;
        end
        @(posedge clk);
        #1;
      end
      req = '0;
      wr_done = 1'b0;
      check("rr_done_count", dones, 4);
      check("rr_grants_left", exp_q.size(), 0);
      repeat (2) @(posedge clk);
      #1;
    end

    // -------------------------------------------------------------------------
    // NACK handling
    // -------------------------------------------------------------------------
    do_reset();
    run_write(2'b01, 99, 3, first_gnt, gnt_frame, gnts, starts, done_v, err_v,
              abort_n, start_cyc, fin_cyc, abort_cyc, both, finished);
    check("nack_finished", finished, 1);
    check("nack_gnts", gnts, 1);
    check("nack_done", done_v, 2'b00);
    check("nack_err", err_v, 2'b01);
    check("nack_abort", abort_n, 0);
    check("nack_exclusive", both, 0);
`ifdef CODEC_ARB_RETRY_EN
    check("nack_starts", starts, 3);
`else
    check("nack_starts", starts, 1);
`endif

    run_write(2'b01, 1, 3, first_gnt, gnt_frame, gnts, starts, done_v, err_v,
              abort_n, start_cyc, fin_cyc, abort_cyc, both, finished);
    check("nack1_finished", finished, 1);
    check("nack1_gnts", gnts, 1);
`ifdef CODEC_ARB_RETRY_EN
    check("nack1_starts", starts, 2);
    check("nack1_done", done_v, 2'b01);
    check("nack1_err", err_v, 2'b00);
`else
    check("nack1_starts", starts, 1);
    check("nack1_done", done_v, 2'b00);
    check("nack1_err", err_v, 2'b01);
`endif

    // -------------------------------------------------------------------------
    // timeout, and completion on the timeout cycle
    // -------------------------------------------------------------------------
    run_write(2'b01, 0, -1, first_gnt, gnt_frame, gnts, starts, done_v, err_v,
              abort_n, start_cyc, fin_cyc, abort_cyc, both, finished);
    check("to_finished", finished, 1);
    check("to_starts", starts, 1);
    check("to_err", err_v, 2'b01);
    check("to_done", done_v, 2'b00);
    check("to_abort_n", abort_n, 1);
    check("to_latency", fin_cyc - start_cyc, 10);
    check("to_abort_cyc", abort_cyc, fin_cyc);

    run_write(2'b01, 0, 9, first_gnt, gnt_frame, gnts, starts, done_v, err_v,
              abort_n, start_cyc, fin_cyc, abort_cyc, both, finished);
    check("tie_finished", finished, 1);
    check("tie_done", done_v, 2'b01);
    check("tie_err", err_v, 2'b00);
    check("tie_abort_n", abort_n, 0);
    check("tie_latency", fin_cyc - start_cyc, 10);

    // -------------------------------------------------------------------------
    // reset in the middle of WAIT
    // -------------------------------------------------------------------------
    begin
      logic seen;
      seen = 1'b0;
      do_reset();
      req_word = {16'hABCD, 16'h0E42};
      req = 2'b01;
      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        if (gnt != '0) req = '0;
        if (dbg_state == 3'd3) begin
          seen = 1'b1;
          break;
        end
        @(posedge clk);
        #1;
      end
      check("mw_reached_wait", seen, 1);
      req = '0;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check_quiet("mw_reset");
      check("mw_reset_frame", wr_frame, 24'h000000);
      @(posedge clk);
      #1;

      // Requester 0 was granted before the reset, so a cleared pointer shows
      // up as requester 0 winning a simultaneous request.
      run_write(2'b11, 0, 3, first_gnt, gnt_frame, gnts, starts, done_v, err_v,
                abort_n, start_cyc, fin_cyc, abort_cyc, both, finished);
      check("mw_ptr_gnt", first_gnt, 2'b01);
      check("mw_ptr_done", done_v, 2'b01);

      run_write(2'b10, 0, 3, first_gnt, gnt_frame, gnts, starts, done_v, err_v,
                abort_n, start_cyc, fin_cyc, abort_cyc, both, finished);
      check("mw_r1_gnt", first_gnt, 2'b10);
      check("mw_r1_frame", gnt_frame, 24'h34ABCD);
      check("mw_r1_done", done_v, 2'b10);
      check("mw_r1_err", err_v, 2'b00);

      // Stray completion while idle.
      wr_done = 1'b1;
      wr_ack_ok = 1'b1;
      @(posedge clk);
      #1;
      wr_done = 1'b0;
      wr_ack_ok = 1'b0;
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        check_quiet($sformatf("stray%0d", c));
        @(posedge clk);
        #1;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
